// File: rtl/conv_pkg.sv
// Shared definitions for the convolution scheduler: FSM states and the
// address-width helper also used by the buffer modules.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } conv_state_t;

  // Width needed to address `depth` entries, never less than one bit.
  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Five nested tap counters (j fastest .. c slowest) and the buffer address
// arithmetic for the current tap.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int I_SIZE     = 8,
  parameter int K_SIZE     = 3,
  parameter int K_CHANNELS = 1,
  localparam int O_SIZE = I_SIZE - K_SIZE + 1,
  localparam int IA_W   = addr_w(I_SIZE * I_SIZE * K_CHANNELS),
  localparam int WA_W   = addr_w(K_SIZE * K_SIZE * K_CHANNELS),
  localparam int RA_W   = addr_w(O_SIZE * O_SIZE * K_CHANNELS)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            clr,
  input  logic            adv,
  output logic [IA_W-1:0] i_addr,
  output logic [WA_W-1:0] w_addr,
  output logic [RA_W-1:0] r_addr,
  output logic            tap_first,
  output logic            tap_last_win,
  output logic            tap_last_all
);

  localparam int KW = addr_w(K_SIZE);
  localparam int OW = addr_w(O_SIZE);
  localparam int CW = addr_w(K_CHANNELS);

  logic [KW-1:0] j, i;
  logic [OW-1:0] x, r;
  logic [CW-1:0] c;
  logic          wrap_j, wrap_i, wrap_x, wrap_r, wrap_c;

  assign wrap_j = (j == KW'(K_SIZE - 1));
  assign wrap_i = (i == KW'(K_SIZE - 1));
  assign wrap_x = (x == OW'(O_SIZE - 1));
  assign wrap_r = (r == OW'(O_SIZE - 1));
  assign wrap_c = (c == CW'(K_CHANNELS - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      j <= '0; i <= '0; x <= '0; r <= '0; c <= '0;
    end else if (clr) begin
      j <= '0; i <= '0; x <= '0; r <= '0; c <= '0;
    end else if (adv) begin
      j <= wrap_j ? '0 : j + 1'b1;
      if (wrap_j)
        i <= wrap_i ? '0 : i + 1'b1;
      if (wrap_j && wrap_i)
        x <= wrap_x ? '0 : x + 1'b1;
      if (wrap_j && wrap_i && wrap_x)
        r <= wrap_r ? '0 : r + 1'b1;
      if (wrap_j && wrap_i && wrap_x && wrap_r)
        c <= wrap_c ? '0 : c + 1'b1;
    end
  end

  assign i_addr = IA_W'(c) * IA_W'(I_SIZE * I_SIZE)
                + (IA_W'(r) + IA_W'(i)) * IA_W'(I_SIZE)
                + IA_W'(x) + IA_W'(j);
  assign w_addr = WA_W'(c) * WA_W'(K_SIZE * K_SIZE)
                + WA_W'(i) * WA_W'(K_SIZE) + WA_W'(j);
  assign r_addr = RA_W'(c) * RA_W'(O_SIZE * O_SIZE)
                + RA_W'(r) * RA_W'(O_SIZE) + RA_W'(x);

  assign tap_first    = (i == '0) && (j == '0);
  assign tap_last_win = wrap_i && wrap_j;
  assign tap_last_all = tap_last_win && wrap_x && wrap_r && wrap_c;

endmodule

// File: rtl/conv_sched.sv
// Depthwise convolution scheduler: sequences buffer reads, MAC control and
// result writes, with a two-stage pipeline matching the one-cycle read latency.
module conv_sched
  import conv_pkg::*;
#(
  parameter int I_SIZE     = 8,
  parameter int K_SIZE     = 3,
  parameter int K_CHANNELS = 1,
  localparam int O_SIZE = I_SIZE - K_SIZE + 1,
  localparam int IA_W   = addr_w(I_SIZE * I_SIZE * K_CHANNELS),
  localparam int WA_W   = addr_w(K_SIZE * K_SIZE * K_CHANNELS),
  localparam int RA_W   = addr_w(O_SIZE * O_SIZE * K_CHANNELS)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            conv_en,
  output logic            i_rd_en,
  output logic [IA_W-1:0] i_addr,
  output logic            w_rd_en,
  output logic [WA_W-1:0] w_addr,
  output logic            acc_clr,
  output logic            acc_en,
  output logic            r_wr_en,
  output logic [RA_W-1:0] r_addr,
  output logic            conv_done
);

  conv_state_t     state, state_nxt;
  logic            issue;
  logic [IA_W-1:0] gen_i_addr;
  logic [WA_W-1:0] gen_w_addr;
  logic [RA_W-1:0] gen_r_addr;
  logic            tap_first, tap_last_win, tap_last_all;

  // Pipeline: stage 0 = issue cycle, stage 1 = read data back, stage 2 = write.
  logic            first_s0, win_s0, win_s1, fin_s0, fin_s1, fin_s2;
  logic [RA_W-1:0] ra_s0, ra_s1;

  conv_addr_gen #(
    .I_SIZE     (I_SIZE),
    .K_SIZE     (K_SIZE),
    .K_CHANNELS (K_CHANNELS)
  ) u_addr_gen (
    .clk          (clk),
    .rstn         (rstn),
    .clr          (state == IDLE),
    .adv          (issue),
    .i_addr       (gen_i_addr),
    .w_addr       (gen_w_addr),
    .r_addr       (gen_r_addr),
    .tap_first    (tap_first),
    .tap_last_win (tap_last_win),
    .tap_last_all (tap_last_all)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE:  if (conv_en) state_nxt = RUN;
      RUN: begin
        if (conv_en) begin
          issue = 1'b1;
          if (tap_last_all) state_nxt = DRAIN;
        end
      end
      DRAIN: if (fin_s2) state_nxt = DONE;
      DONE:  if (!conv_en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      i_rd_en  <= 1'b0;
      w_rd_en  <= 1'b0;
      i_addr   <= '0;
      w_addr   <= '0;
      first_s0 <= 1'b0;
      win_s0   <= 1'b0;
      fin_s0   <= 1'b0;
      ra_s0    <= '0;
      acc_en   <= 1'b0;
      acc_clr  <= 1'b0;
      win_s1   <= 1'b0;
      fin_s1   <= 1'b0;
      ra_s1    <= '0;
      r_wr_en  <= 1'b0;
      fin_s2   <= 1'b0;
      r_addr   <= '0;
    end else begin
      i_rd_en  <= issue;
      w_rd_en  <= issue;
      first_s0 <= issue && tap_first;
      win_s0   <= issue && tap_last_win;
      fin_s0   <= issue && tap_last_all;
      if (issue) begin
        i_addr <= gen_i_addr;
        w_addr <= gen_w_addr;
      end
      if (issue && tap_last_win)
        ra_s0 <= gen_r_addr;

      acc_en  <= i_rd_en;
      acc_clr <= i_rd_en && first_s0;
      win_s1  <= win_s0;
      fin_s1  <= fin_s0;
      if (win_s0)
        ra_s1 <= ra_s0;

      r_wr_en <= win_s1;
      fin_s2  <= fin_s1;
      if (win_s1)
        r_addr <= ra_s1;
    end
  end

  assign conv_done = (state == DONE);

endmodule

// File: tb/tb_conv_sched.sv
// Self-checking bench for conv_sched: two configurations, a per-cycle
// reference built from nested loops over the tap order, directed and random conv_en.
module tb_conv_sched;

  logic clk = 1'b0;
  logic rstn;
  logic en_a, en_b;
  int   sel;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  // Instance A: I=4, K=3, C=2
  logic       a_i_rd, a_w_rd, a_clr, a_acc, a_wr, a_done;
  logic [4:0] a_ia;
  logic [4:0] a_wa;
  logic [2:0] a_ra;
  // Instance B: I=3, K=1, C=1
  logic       b_i_rd, b_w_rd, b_clr, b_acc, b_wr, b_done;
  logic [3:0] b_ia;
  logic [0:0] b_wa;
  logic [3:0] b_ra;

  conv_sched #(.I_SIZE(4), .K_SIZE(3), .K_CHANNELS(2)) u_a (
    .clk(clk), .rstn(rstn), .conv_en(en_a),
    .i_rd_en(a_i_rd), .i_addr(a_ia), .w_rd_en(a_w_rd), .w_addr(a_wa),
    .acc_clr(a_clr), .acc_en(a_acc), .r_wr_en(a_wr), .r_addr(a_ra),
    .conv_done(a_done)
  );

  conv_sched #(.I_SIZE(3), .K_SIZE(1), .K_CHANNELS(1)) u_b (
    .clk(clk), .rstn(rstn), .conv_en(en_b),
    .i_rd_en(b_i_rd), .i_addr(b_ia), .w_rd_en(b_w_rd), .w_addr(b_wa),
    .acc_clr(b_clr), .acc_en(b_acc), .r_wr_en(b_wr), .r_addr(b_ra),
    .conv_done(b_done)
  );

  logic        o_rd, o_wrd, o_clr, o_acc, o_wr, o_done;
  logic [31:0] o_ia, o_wa, o_ra;

  always_comb begin
    if (sel == 1) begin
      o_rd = b_i_rd; o_wrd = b_w_rd; o_clr = b_clr; o_acc = b_acc;
      o_wr = b_wr;   o_done = b_done;
      o_ia = 32'(b_ia); o_wa = 32'(b_wa); o_ra = 32'(b_ra);
    end else begin
      o_rd = a_i_rd; o_wrd = a_w_rd; o_clr = a_clr; o_acc = a_acc;
      o_wr = a_wr;   o_done = a_done;
      o_ia = 32'(a_ia); o_wa = 32'(a_wa); o_ra = 32'(a_ra);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_en(input int s, input logic v);
    if (s == 1) en_b = v;
    else        en_a = v;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd"},   32'(o_rd),   0);
    chk({tag, "_wrd"},  32'(o_wrd),  0);
    chk({tag, "_acc"},  32'(o_acc),  0);
    chk({tag, "_clr"},  32'(o_clr),  0);
    chk({tag, "_wr"},   32'(o_wr),   0);
    chk({tag, "_done"}, 32'(o_done), 0);
    chk({tag, "_ia"},   o_ia, 0);
    chk({tag, "_wa"},   o_wa, 0);
    chk({tag, "_ra"},   o_ra, 0);
  endtask

  // mode 0: conv_en always high; 1: five-cycle pause starting at pause_at;
  // 2: random conv_en. rst_at > 0 aborts the run with a reset pulse after that cycle.
  task automatic run_conv(input int s, input int isz, input int ksz, input int ch,
                          input int mode, input int pause_at, input int rst_at);
    int  ia_q[$], wa_q[$], ra_q[$];
    bit  first_q[$], last_q[$];
    int  issued[0:1023];
    int  osz, n_taps, next, final_t, t, p1, p2, rd_cnt, done_t;
    bit  en, exp_rd, exp_acc, exp_wr, exp_done;

    osz = isz - ksz + 1;
    for (int c = 0; c < ch; c++)
      for (int r = 0; r < osz; r++)
        for (int x = 0; x < osz; x++)
          for (int i = 0; i < ksz; i++)
            for (int j = 0; j < ksz; j++) begin
              ia_q.push_back(c*isz*isz + (r+i)*isz + (x+j));
              wa_q.push_back(c*ksz*ksz + i*ksz + j);
              ra_q.push_back(c*osz*osz + r*osz + x);
              first_q.push_back(i == 0 && j == 0);
              last_q.push_back(i == ksz-1 && j == ksz-1);
            end
    n_taps = ia_q.size();
    foreach (issued[k]) issued[k] = -1;

    sel = s;
    @(negedge clk);
    set_en(s, 1'b1);
    @(posedge clk);
    next = 0; final_t = -1; t = 0; rd_cnt = 0; done_t = -1;

    while (1) begin
      t++;
      if (t > 1000) begin
        chk("run_timeout", 32'(t), 0);
        break;
      end
      if (next >= n_taps)   en = 1'b1;
      else if (mode == 1)   en = !(t >= pause_at && t < pause_at + 5);
      else if (mode == 2)   en = ($urandom_range(0, 3) != 0);
      else                  en = 1'b1;
      set_en(s, en);
      @(posedge clk);
      if (en && next < n_taps) begin
        issued[t] = next;
        next++;
        if (next == n_taps) final_t = t;
      end
      @(negedge clk);

      exp_rd = (issued[t] >= 0);
      chk("i_rd_en", 32'(o_rd),  32'(exp_rd));
      chk("w_rd_en", 32'(o_wrd), 32'(exp_rd));
      if (exp_rd) begin
        chk("i_addr", o_ia, ia_q[issued[t]]);
        chk("w_addr", o_wa, wa_q[issued[t]]);
      end
      if (o_rd === 1'b1) rd_cnt++;
      p1 = issued[t-1];
      exp_acc = (p1 >= 0);
      chk("acc_en",  32'(o_acc), 32'(exp_acc));
      chk("acc_clr", 32'(o_clr), 32'(exp_acc && first_q[exp_acc ? p1 : 0]));
      p2 = (t >= 2) ? issued[t-2] : -1;
      exp_wr = (p2 >= 0) && last_q[(p2 >= 0) ? p2 : 0];
      chk("r_wr_en", 32'(o_wr), 32'(exp_wr));
      if (exp_wr) chk("r_addr", o_ra, ra_q[p2]);
      exp_done = (final_t > 0) && (t >= final_t + 3);
      chk("conv_done", 32'(o_done), 32'(exp_done));
      if (o_done === 1'b1 && done_t < 0) done_t = t;

      if (rst_at > 0 && t == rst_at) begin
        rstn = 1'b0;
        #1;
        chk_all_zero("abort");
        set_en(s, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk_all_zero("post_abort");
        return;
      end
      if (final_t > 0 && t == final_t + 4) break;
    end

    set_en(s, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("done_clear", 32'(o_done), 0);
    chk("issue_count", 32'(rd_cnt), 32'(n_taps));
    if (mode == 0) chk("done_rise", 32'(done_t), 32'(n_taps + 3));
    if (mode == 1) chk("done_rise_paused", 32'(done_t), 32'(n_taps + 3 + 5));
  endtask

  initial begin
    rstn = 1'b0; en_a = 1'b0; en_b = 1'b0; sel = 0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset_a");
    sel = 1;
    #1;
    chk_all_zero("reset_b");
    rstn = 1'b1;
    @(negedge clk);

    run_conv(0, 4, 3, 2, 0, 0, 0);
    run_conv(0, 4, 3, 2, 1, 5, 0);
    run_conv(0, 4, 3, 2, 0, 0, 20);
    run_conv(0, 4, 3, 2, 0, 0, 0);
    run_conv(1, 3, 1, 1, 0, 0, 0);
    run_conv(1, 3, 1, 1, 1, 4, 0);
    run_conv(1, 3, 1, 1, 2, 0, 0);
    run_conv(0, 4, 3, 2, 2, 0, 0);
    run_conv(1, 3, 1, 1, 0, 0, 5);
    run_conv(1, 3, 1, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_sched.md
CONV_SCHED -- requirements
Module: conv_sched

Interface
REQ-001 Parameter I_SIZE, default 8, input feature map side length in pixels.
REQ-002 Parameter K_SIZE, default 3, kernel side length; constraint 1 <= K_SIZE <= I_SIZE.
REQ-003 Parameter K_CHANNELS, default 1, number of depthwise channels; output channels equal K_CHANNELS.
REQ-004 Derived constant O_SIZE SHALL equal I_SIZE-K_SIZE+1; derived address widths SHALL be clog2 of I_SIZE*I_SIZE*K_CHANNELS, K_SIZE*K_SIZE*K_CHANNELS and O_SIZE*O_SIZE*K_CHANNELS (minimum 1).
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rstn  input  1  reset, asynchronous and active-low.
REQ-007 conv_en  input  1  start request; holds operation while high.
REQ-008 i_rd_en / i_addr  output  1 / IA_W  input-buffer read strobe and address.
REQ-009 w_rd_en / w_addr  output  1 / WA_W  weight-buffer read strobe and address.
REQ-010 acc_clr  output  1  clear MAC accumulator before loading the first product of a window.
REQ-011 acc_en  output  1  accumulate the buffer read data returned this cycle.
REQ-012 r_wr_en / r_addr  output  1 / RA_W  result-buffer write strobe and address.
REQ-013 conv_done  output  1  whole convolution complete.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-015 IDLE->RUN on a rising edge with conv_en=1; counters are zeroed on entry.
REQ-016 In RUN, each cycle with conv_en=1 SHALL issue one tap: i_rd_en=w_rd_en=1, and the tap counters advance in the order j (kernel col, fastest), i (kernel row), x (out col), r (out row), c (channel, slowest).
REQ-017 Addresses SHALL be i_addr=c*I_SIZE^2+(r+i)*I_SIZE+(x+j), w_addr=c*K_SIZE^2+i*K_SIZE+j, r_addr=c*O_SIZE^2+r*O_SIZE+x.
REQ-018 Buffer read latency is one cycle: acc_en SHALL be asserted exactly one cycle after each issue, with acc_clr asserted in that same cycle when the tap is i=0,j=0.
REQ-019 r_wr_en SHALL be asserted two cycles after issue of the last tap of a window (i=j=K_SIZE-1), with r_addr for that window registered alongside it.
REQ-020 conv_en=0 during RUN SHALL pause issue (no rd_en, counters frozen); in-flight acc_en/r_wr_en still complete; issue resumes on the next cycle with conv_en=1 without loss or repetition.
REQ-021 RUN->DRAIN after issuing the final tap (c=K_CHANNELS-1, r=x=O_SIZE-1, i=j=K_SIZE-1); DRAIN->DONE after the final r_wr_en.
REQ-022 In DONE conv_done SHALL be 1; DONE->IDLE when conv_en=0; conv_done clears on the same edge.
REQ-023 K_SIZE=1 SHALL assert acc_clr and acc_en together on every tap and r_wr_en for every tap.
REQ-024 Total issue cycles SHALL be O_SIZE^2*K_SIZE^2*K_CHANNELS with no bubbles when conv_en stays high.

Reset
REQ-025 rstn=0 SHALL asynchronously force IDLE, all counters and pipeline valid bits to 0, and every output (strobes, addresses, conv_done) to 0.
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no further strobes; the next start restarts from tap 0.

Structure
REQ-027 Package conv_pkg SHALL hold the FSM state enum and a clog2-based address-width function shared with the buffer modules.
REQ-028 One sub-module conv_addr_gen SHALL contain the five nested counters, wrap flags and address arithmetic; conv_sched holds the FSM and the latency pipeline.

Verification
REQ-029 I=4,K=3,C=1, conv_en high at start edge S -> i_addr first window 0,1,2,4,5,6,8,9,10 on S+1..S+9; w_addr 0..8; acc_clr at S+2.
REQ-030 Same config -> r_wr_en at S+11,S+20,S+29,S+38 with r_addr 0,1,2,3; conv_done rises at S+39.
REQ-031 I=4,K=3,C=2 -> second-channel first tap i_addr=16, w_addr=9; last r_addr=7; 72 issue cycles.
REQ-032 conv_en low for 5 cycles mid-window -> no rd_en during pause, address sequence continuous, conv_done delayed exactly 5 cycles.
REQ-033 rstn pulsed low mid-RUN -> all outputs 0 immediately; restart yields i_addr=0 first.
REQ-034 K=1,I=3,C=1 -> 9 taps, r_wr_en on 9 consecutive cycles S+3..S+11, r_addr 0..8.
